// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared widths and brightness window helper for the seven-segment scan controller
package seg_scan_pkg;

  localparam int DIGIT_W    = 3;
  localparam int DIGITS_DEF = 8;
  localparam int IDX_W      = $clog2(DIGITS_DEF);

  // Lit cycles per slot for a 3-bit brightness level; level 7 yields the whole span.
  function automatic int on_window(input int span, input logic [2:0] bright);
    return (span * (int'(bright) + 1)) / 8;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// rtl/seg_scan_ctrl_prescaler.sv - slot prescaler: counts 0..DIV-1 while enabled, synchronous clear
module scan_prescaler #(
  parameter int DIV = 1000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          slot_end
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign slot_end = en && !clr && (cnt_q == CW'(DIV - 1));
  assign count    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-seg digit scanner with double-buffered frame load
// Optional SEG_SCAN_BRIGHT_EN adds a bright[2:0] input that trims the lit window per slot.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = DIGITS_DEF,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [2:0]                bright,
`endif
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [DIGIT_W*DIGITS-1:0] load_data,
  output logic [DIGIT_W-1:0]        sel_code,
  output logic [DIGITS-1:0]         den,
  output logic                      frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]     BLANK_C = CW'(BLANK_CYC);
  localparam logic [DIGITS-1:0] DEN_ONE = DIGITS'(1);

  logic [CW-1:0]             presc;
  logic                      slot_end;
  logic                      wrap;
  logic                      in_on;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGIT_W*DIGITS-1:0] active_q, active_d;
  logic [DIGIT_W*DIGITS-1:0] pend_q, pend_d;
  logic                      pend_vld_q, pend_vld_d;
  logic                      ready_q;
  logic [DIGITS-1:0]         den_q, den_d;
  logic [DIGIT_W-1:0]        sel_q, sel_d;
  logic                      tick_q, tick_d;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [CW-1:0]             on_q, on_d;
`endif

  scan_prescaler #(.DIV(SCAN_DIV)) u_presc (
    .clk      (clk),
    .rst_n    (reset),
    .en       (enable),
    .clr      (!enable),
    .count    (presc),
    .slot_end (slot_end)
  );

  assign wrap = slot_end && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    idx_d      = idx_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = wrap;

    if (!enable) begin
      idx_d = '0;
    end else if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    // Promote only at a frame boundary, or at once while the display is dark.
    if (pend_vld_q && (wrap || !enable)) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (load_valid && ready_q) begin
      pend_d     = load_data;
      pend_vld_d = 1'b1;
    end

`ifdef SEG_SCAN_BRIGHT_EN
    on_d  = (presc == '0) ? CW'(on_window(SCAN_DIV - BLANK_CYC, bright)) : on_q;
    in_on = (presc >= BLANK_C) && (int'(presc) < BLANK_CYC + int'(on_d));
`else
    in_on = (presc >= BLANK_C);
`endif

    den_d = (enable && in_on) ? (DEN_ONE << idx_q) : '0;
    sel_d = active_q[DIGIT_W*int'(idx_q) +: DIGIT_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      den_q      <= '0;
      sel_q      <= '0;
      tick_q     <= 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
      on_q       <= '0;
`endif
    end else begin
      idx_q      <= idx_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= !pend_vld_d;
      den_q      <= den_d;
      sel_q      <= sel_d;
      tick_q     <= tick_d;
`ifdef SEG_SCAN_BRIGHT_EN
      on_q       <= on_d;
`endif
    end
  end

  assign load_ready = ready_q;
  assign den        = den_q;
  assign sel_code   = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [23:0] load_data;
  logic [2:0]  sel_code;
  logic [7:0]  den;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers = 0;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
`ifdef SEG_SCAN_BRIGHT_EN
    .bright     (3'd7),
`endif
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sel_code   (sel_code),
    .den        (den),
    .frame_tick (frame_tick)
  );

`ifdef SEG_SCAN_BRIGHT_EN
  logic [2:0] bright_b;
  logic       ready_b;
  logic [2:0] sel_b;
  logic [7:0] den_b;
  logic       tick_b;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(10), .BLANK_CYC(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bright     (bright_b),
    .load_valid (1'b0),
    .load_ready (ready_b),
    .load_data  (24'd0),
    .sel_code   (sel_b),
    .den        (den_b),
    .frame_tick (tick_b)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the source drops load_valid once a transfer has happened.
  task automatic step();
    logic x;
    x = load_valid && load_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (x) begin
      load_valid = 1'b0;
      xfers++;
    end
  endtask

  task automatic check_frame(input logic [23:0] codes, input int n, input string tag);
    int k;
    for (int i = 0; i < n; i++) begin
      step();
      if (den != 8'h00) begin
        k = 0;
        for (int j = 0; j < 8; j++) if (den[j]) k = j;
        chk(tag, {29'd0, sel_code}, {29'd0, codes[3*k +: 3]});
      end
    end
  endtask

  task automatic wait_den(input logic [7:0] want, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (den == want) break;
      step();
    end
    chk(tag, {24'd0, den}, {24'd0, want});
  endtask

  task automatic wait_tick(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (frame_tick) break;
      step();
    end
    chk(tag, {31'd0, frame_tick}, 32'd1);
  endtask

  logic [7:0] den_tab [16];
  int ntick, t1, t2, cnt;

  initial begin
    den_tab = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
`ifdef SEG_SCAN_BRIGHT_EN
    bright_b   = 3'd3;
`endif
    #1 reset = 1'b0;
    step(); step();
    chk("rst_den",   {24'd0, den}, 32'd0);
    chk("rst_sel",   {29'd0, sel_code}, 32'd0);
    chk("rst_tick",  {31'd0, frame_tick}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);

    // 1: scan pattern and frame period
    reset  = 1'b1;
    enable = 1'b1;
    cyc    = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("scan_den", {24'd0, den}, {24'd0, den_tab[k]});
    end
    ntick = 0; t1 = 0; t2 = 0;
    while (cyc < 130) begin
      step();
      if (frame_tick) begin
        ntick++;
        if (ntick == 1) t1 = cyc;
        if (ntick == 2) t2 = cyc;
      end
    end
    chk("tick_first",  t1, 32'd64);
    chk("tick_period", t2 - t1, 32'd64);
    chk("tick_count",  ntick, 32'd2);

    // 2: single frame load
    chk("ld_ready_idle", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = 24'o76543210;
    step();
    chk("ld_ready_drop", {31'd0, load_ready}, 32'd0);
    chk("ld_xfer", xfers, 32'd1);
    wait_tick("ld_tick");
    chk("ld_ready_back", {31'd0, load_ready}, 32'd1);
    check_frame(24'o76543210, 64, "frame_a");
    chk("frame_a_end_tick", {31'd0, frame_tick}, 32'd1);

    // 3: back-to-back loads, second held off until the first wrap
    load_valid = 1'b1;
    load_data  = 24'o11111111;
    step();
    chk("b2b_ready0", {31'd0, load_ready}, 32'd0);
    chk("b2b_xfer1", xfers, 32'd2);
    load_valid = 1'b1;
    load_data  = 24'o22222222;
    check_frame(24'o76543210, 63, "b2b_old");
    chk("b2b_held", xfers, 32'd2);
    chk("b2b_ready1", {31'd0, load_ready}, 32'd1);
    check_frame(24'o11111111, 64, "b2b_f1");
    chk("b2b_xfer2", xfers, 32'd3);
    check_frame(24'o22222222, 64, "b2b_f2");

    // 4: disable during digit 3, load while dark, re-enable
    wait_den(8'h08, "dis_find_d3");
    enable = 1'b0;
    step();
    chk("dis_den", {24'd0, den}, 32'd0);
    chk("dis_tick", {31'd0, frame_tick}, 32'd0);
    load_valid = 1'b1;
    load_data  = 24'o01234567;
    step();
    chk("dis_ready0", {31'd0, load_ready}, 32'd0);
    step();
    chk("dis_ready1", {31'd0, load_ready}, 32'd1);
    step();
    chk("dis_promote", {29'd0, sel_code}, 32'd7);
    enable = 1'b1;
    step(); chk("reen_blank0", {24'd0, den}, 32'd0);
    step(); chk("reen_blank1", {24'd0, den}, 32'd0);
    step(); chk("reen_d0",     {24'd0, den}, 32'h01);

    // 5: async reset mid-slot with pending data
    wait_den(8'h02, "ar_find_d1");
    chk("ar_sel_pre", {29'd0, sel_code}, 32'd6);
    load_valid = 1'b1;
    load_data  = 24'o55555555;
    step();
    chk("ar_pend", {31'd0, load_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("ar_den",   {24'd0, den}, 32'd0);
    chk("ar_sel",   {29'd0, sel_code}, 32'd0);
    chk("ar_tick",  {31'd0, frame_tick}, 32'd0);
    chk("ar_ready", {31'd0, load_ready}, 32'd1);
    step(); step();
    reset = 1'b1;
    check_frame(24'o00000000, 80, "ar_codes");
    wait_den(8'h01, "ar_rescan");

`ifdef SEG_SCAN_BRIGHT_EN
    // 6: brightness window on the SCAN_DIV=10 instance
    bright_b = 3'd3;
    repeat (20) step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (den_b != 8'h00) cnt++; end
    chk("bright3", cnt, 32'd4);
    bright_b = 3'd7;
    repeat (20) step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (den_b != 8'h00) cnt++; end
    chk("bright7", cnt, 32'd8);
    bright_b = 3'd0;
    repeat (20) step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (den_b != 8'h00) cnt++; end
    chk("bright0", cnt, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
